prog_ctr_unit: RTL and testbench

- Fetch-stage program counter. Drives the address into the instruction ROM and sequences execution: increment, absolute jump, PC-relative branch, stall, halt.
- The ROM is combinational, so the instruction for `prog_ctr` is valid in the same cycle. The decoder's control outputs for that instruction return here and select the next PC.
- Also tracks run state (idle/run/done) and a retired-instruction counter for the bench and top level.

---
 rtl/prog_ctr_unit.sv | 92 +++++++++
 tb/tb_prog_ctr_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr_unit.sv
// Fetch-stage program counter with idle/run/done sequencing and a saturating
// retired-instruction counter.
module prog_ctr_unit #(
    parameter int unsigned D          = 12,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned OFF_W      = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             abs_jump,
    input  logic             rel_branch,
    input  logic             branch_taken,
    input  logic [D-1:0]     target,
    input  logic [OFF_W-1:0] offset,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    // One-hot-ish encoding so the status outputs are plain state flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [D-1:0]     pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [D-1:0]     off_ext;
    logic [D-1:0]     next_pc;
    logic [CNT_W-1:0] cnt_inc;

    assign off_ext = D'($signed(offset));

    // Non-restart, non-halt, non-stall successor; absolute jump beats branch.
    always_comb begin
        next_pc = pc_q + D'(1);
        if (abs_jump) begin
            next_pc = target;
        end else if (rel_branch && branch_taken) begin
            next_pc = pc_q + off_ext;
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (start) begin
                        pc_q  <= START_PC;
                        cnt_q <= '0;
                    end else if (halt) begin
                        state <= DONE;
                        cnt_q <= cnt_inc;
                    end else if (!stall) begin
                        pc_q  <= next_pc;
                        cnt_q <= cnt_inc;
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        pc_q  <= START_PC;
                        cnt_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign prog_ctr    = pc_q;
    assign fetch_valid = state[0];
    assign done        = state[1];
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_prog_ctr_unit.sv
// Self-checking bench for prog_ctr_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_prog_ctr_unit;

    localparam int unsigned D       = 12;
    localparam int unsigned OFF_W   = 8;
    localparam int          PC_MOD  = 4096;
    localparam int          MAX16   = 65535;
    localparam int          MAX4    = 15;

    logic             clk = 1'b0;
    logic             reset, start, stall, halt, abs_jump, rel_branch, branch_taken;
    logic [D-1:0]     target;
    logic [OFF_W-1:0] offset;
    logic [D-1:0]     prog_ctr, pc4;
    logic             fetch_valid, done, fv4, dn4;
    logic [15:0]      instr_count;
    logic [3:0]       cnt4;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: 0 idle, 1 run, 2 done; m_ret is unbounded retirements.
    int m_st, m_pc, m_ret;

    typedef struct {
        logic       start, stall, halt, abs_jump, rel_branch, branch_taken;
        logic [11:0] target;
        logic [7:0]  offset;
        logic [11:0] pc;
        logic        fv, dn;
        int          ret;
    } vec_t;

    vec_t vecs[$];

    prog_ctr_unit #(.D(D), .START_ADDR(0), .OFF_W(OFF_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .abs_jump(abs_jump), .rel_branch(rel_branch), .branch_taken(branch_taken),
        .target(target), .offset(offset), .prog_ctr(prog_ctr),
        .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
    );

    prog_ctr_unit #(.D(D), .START_ADDR(0), .OFF_W(OFF_W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .abs_jump(abs_jump), .rel_branch(rel_branch), .branch_taken(branch_taken),
        .target(target), .offset(offset), .prog_ctr(pc4),
        .fetch_valid(fv4), .done(dn4), .instr_count(cnt4)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pc = 0; m_ret = 0;
    endtask

    task automatic model_step();
        if (m_st != 1) begin
            if (start) begin m_st = 1; m_pc = 0; m_ret = 0; end
        end else if (start) begin
            m_pc = 0; m_ret = 0;
        end else if (halt) begin
            m_st = 2; m_ret++;
        end else if (!stall) begin
            if (abs_jump) m_pc = int'(target);
            else if (rel_branch && branch_taken)
                m_pc = ((m_pc + int'($signed(offset))) % PC_MOD + PC_MOD) % PC_MOD;
            else m_pc = (m_pc + 1) % PC_MOD;
            m_ret++;
        end
    endtask

    task automatic set_in(input logic s, input logic st, input logic h, input logic aj,
                          input logic rb, input logic bt, input logic [11:0] t,
                          input logic [7:0] o);
        start = s; stall = st; halt = h; abs_jump = aj; rel_branch = rb;
        branch_taken = bt; target = t; offset = o;
    endtask

    task automatic add(input logic s, input logic st, input logic h, input logic aj,
                       input logic rb, input logic bt, input logic [11:0] t,
                       input logic [7:0] o, input logic [11:0] pc, input logic fv,
                       input logic dn, input int ret);
        vec_t v;
        v.start = s; v.stall = st; v.halt = h; v.abs_jump = aj; v.rel_branch = rb;
        v.branch_taken = bt; v.target = t; v.offset = o;
        v.pc = pc; v.fv = fv; v.dn = dn; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int exp_pc, input logic exp_fv,
                         input logic exp_dn, input int exp_ret);
        int e16, e4;
        e16 = sat(exp_ret, MAX16);
        e4  = sat(exp_ret, MAX4);
        vectors++;
        if (int'(prog_ctr) != exp_pc || fetch_valid !== exp_fv || done !== exp_dn ||
            int'(instr_count) != e16 || int'(pc4) != exp_pc || fv4 !== exp_fv ||
            dn4 !== exp_dn || int'(cnt4) != e4) begin
            miscompares++;
            $display("FAIL %s: got pc=%h fv=%b done=%b cnt=%0d | cnt4=%0d pc4=%h fv4=%b done4=%b ; expected pc=%h fv=%b done=%b cnt=%0d cnt4=%0d",
                     name, prog_ctr, fetch_valid, done, instr_count, cnt4, pc4, fv4, dn4,
                     exp_pc, exp_fv, exp_dn, e16, e4);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_pc, logic'(m_st == 1), logic'(m_st == 2), m_ret);
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        model_reset();
        #3;
        check("reset_state", 0, 0, 0, 0);
        #10 reset = 1'b0;

        // IDLE ignores control flags other than start.
        set_in(0, 1, 1, 1, 1, 1, 12'h123, 8'h05);
        tick();
        check("idle_ignores", 0, 0, 0, 0);

        // Directed vectors: s st h aj rb bt target offset -> pc fv dn retired
        add(1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 1, 0, 0);
        for (int i = 1; i <= 5; i++)
            add(0, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'(i), 1, 0, i);
        add(0, 0, 0, 1, 0, 0, 12'h010, 8'h00, 12'h010, 1, 0, 6);
        add(0, 0, 0, 1, 0, 0, 12'h3A0, 8'h00, 12'h3A0, 1, 0, 7);
        add(0, 0, 0, 0, 1, 1, 12'h000, 8'hF0, 12'h390, 1, 0, 8);
        add(0, 0, 0, 0, 1, 0, 12'h000, 8'hF0, 12'h391, 1, 0, 9);
        add(0, 0, 0, 1, 0, 0, 12'hFFF, 8'h00, 12'hFFF, 1, 0, 10);
        add(0, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 1, 0, 11);
        add(0, 0, 0, 1, 0, 0, 12'h002, 8'h00, 12'h002, 1, 0, 12);
        add(0, 0, 0, 0, 1, 1, 12'h000, 8'hFB, 12'hFFD, 1, 0, 13);
        add(0, 0, 0, 1, 1, 1, 12'h007, 8'h10, 12'h007, 1, 0, 14);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 1, 0, 0, 12'h200, 8'h00, 12'h007, 1, 0, 14);
        add(0, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h008, 1, 0, 15);
        add(0, 0, 0, 1, 0, 0, 12'h00C, 8'h00, 12'h00C, 1, 0, 16);
        add(0, 1, 1, 1, 0, 0, 12'h300, 8'h00, 12'h00C, 0, 1, 17);

        foreach (vecs[i]) begin
            set_in(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].abs_jump,
                   vecs[i].rel_branch, vecs[i].branch_taken, vecs[i].target, vecs[i].offset);
            tick();
            check($sformatf("vec%0d", i), int'(vecs[i].pc), vecs[i].fv, vecs[i].dn, vecs[i].ret);
        end

        // DONE holds for 10 cycles against arbitrary non-start controls.
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 12'($urandom), 8'($urandom));
            tick();
            check("done_hold", 12'h00C, 0, 1, 17);
        end

        set_in(1, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        tick();
        check("restart_from_done", 0, 1, 0, 0);

        // Async reset in the middle of a cycle while at 0x055.
        set_in(0, 0, 0, 1, 0, 0, 12'h055, 8'h00);
        tick();
        check("jump_055", 12'h055, 1, 0, 1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_midcycle", 0, 0, 0, 0);
        @(posedge clk); #1;
        check("reset_held", 0, 0, 0, 0);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        tick();
        check("idle_after_reset", 0, 0, 0, 0);

        // Saturation of the 4-bit counter over 20 unstalled cycles.
        set_in(1, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        tick();
        check("sat_start", 0, 1, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat_run", i, 1, 0, i);
        end
        start = 1'b1;
        tick();
        check("restart_mid_run", 0, 1, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 2) == 0), 1'($urandom),
                   12'($urandom), 8'($urandom));
            if (i < 5) start = 1'b1;
            tick();
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
